// File: rtl/data_mem_responder_if.sv
`default_nettype none
// =============================================================================
// data_mem_responder_if : request/response bus between initiator and memory
// Revision: 1.0
// =============================================================================
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// =============================================================================
// data_mem_responder : single-outstanding word memory with fixed response latency
// Revision: 1.0
// =============================================================================
module data_mem_responder #(
  parameter int MEM_DEPTH = 1024,
  parameter int LATENCY   = 2
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  data_mem_responder_if.slave bus
);

  localparam int          C_AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0]  C_CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [31:0] C_DEPTH    = 32'(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nxt;
  logic            w_accept;
  logic            w_commit;
  logic            w_release;

  logic            r_write;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_wstrb;
  logic [31:0]     r_rdata;
  logic            r_err;

  logic [31:0]     mem [MEM_DEPTH];
  logic            w_bad;
  logic [C_AW-1:0] w_idx;

  assign w_bad = (r_addr[1:0] != 2'b00) || ({2'b00, r_addr[31:2]} >= C_DEPTH);
  assign w_idx = r_addr[C_AW+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = C_CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request fields are captured once and held until the response completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
    end else if (w_accept) begin
      r_write <= bus.req_write;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
      r_wstrb <= bus.req_wstrb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_commit) begin
      r_err   <= w_bad;
      r_rdata <= (w_bad || r_write) ? 32'd0 : mem[w_idx];
    end else if (w_release) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end
  end

  // Storage has no reset; an aborted request never reaches its commit edge.
  always_ff @(posedge clk) begin
    if (w_commit && r_write && !w_bad) begin
      for (int b = 0; b < 4; b++) begin
        if (r_wstrb[b]) begin
          mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.req_ready = rst_n && (r_state == ST_IDLE);
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// =============================================================================
// tb_data_mem_responder : directed + random checks against a word-array model
// Revision: 1.0
// =============================================================================
module tb_data_mem_responder;
  localparam int LAT   = 2;
  localparam int DEPTH = 1024;
  localparam int NWIN  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if bus ();
  data_mem_responder_if bus1 ();

  data_mem_responder #(.MEM_DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  data_mem_responder #(.MEM_DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] model [NWIN];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
  endfunction

  // Reference: legal addresses used by the bench all fall in a 16-word window.
  task automatic model_apply(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] er, output logic ee);
    ee = is_err(a);
    er = 32'd0;
    if (!ee) begin
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) model[a[5:2]][8*b +: 8] = d[8*b +: 8];
      end else begin
        er = model[a[5:2]];
      end
    end
  endtask

  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int stall);
    logic [31:0] er;
    logic        ee;
    int          k;
    model_apply(w, a, d, s, er, ee);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wstrb = s;
    k = 0;
    while (!bus.req_ready && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_write = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_wstrb = 4'($urandom);
    k = 0;
    while (!bus.rsp_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency", 32'(k), 32'(LAT));
    chk("rsp_rdata", bus.rsp_rdata, er);
    chk("rsp_err", 32'(bus.rsp_err), 32'(ee));
    chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
    repeat (stall) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rdata", bus.rsp_rdata, er);
      chk("hold_err", 32'(bus.rsp_err), 32'(ee));
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("post_hs_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_hs_ready", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    int          last;
    int          nrsp;
    bus.req_valid  = 1'b0; bus.req_write  = 1'b0; bus.req_addr  = 32'd0;
    bus.req_wdata  = 32'd0; bus.req_wstrb = 4'd0;  bus.rsp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = 32'd0;
    bus1.req_wdata = 32'd0; bus1.req_wstrb = 4'd0; bus1.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_err", 32'(bus.rsp_err), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < NWIN; i++) xact(1'b1, 32'(i * 4), $urandom, 4'hF, 0);

    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, 0);
    xact(1'b1, 32'h10, 32'h000000AA, 4'h1, 0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, 0);
    xact(1'b0, 32'h13, 32'h0, 4'h0, 0);
    xact(1'b0, 32'h1000, 32'h0, 4'h0, 0);
    xact(1'b1, 32'h13, 32'h11111111, 4'hF, 0);
    xact(1'b1, 32'h1010, 32'h22222222, 4'hF, 0);
    xact(1'b1, 32'h10, 32'h33333333, 4'h0, 0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, 5);

    // Reset lands between acceptance and the commit edge of a store.
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h20;
    bus.req_wdata = 32'h12345678; bus.req_wstrb = 4'hF;
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_req_ready", 32'(bus.req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_valid_late", 32'(bus.rsp_valid), 32'd0);
    chk("abort_rdata", bus.rsp_rdata, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("abort_rel_ready", 32'(bus.req_ready), 32'd1);
    xact(1'b0, 32'h20, 32'h0, 4'h0, 0);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) != 0) a = 32'($urandom_range(0, NWIN - 1) * 4);
      else if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, NWIN - 1) * 4 + $urandom_range(1, 3));
      else a = 32'h1000 + ($urandom & 32'h0FFF_FFFF);
      xact(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
    end

    // LATENCY=1 instance, requests and response acceptance held continuously.
    bus1.req_valid = 1'b1; bus1.req_write = 1'b0; bus1.req_addr = 32'h1;
    bus1.rsp_ready = 1'b1;
    last = -1;
    nrsp = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      chk("b2b_one_outstanding", 32'(bus1.rsp_valid & bus1.req_ready), 32'd0);
      if (bus1.rsp_valid) begin
        if (last >= 0) chk("b2b_gap", 32'(c - last), 32'd3);
        chk("b2b_err", 32'(bus1.rsp_err), 32'd1);
        chk("b2b_rdata", bus1.rsp_rdata, 32'd0);
        last = c;
        nrsp++;
      end
    end
    chk("b2b_count", 32'(nrsp), 32'd10);
    bus1.req_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
